// File: rtl/audio_frame_scheduler.sv
// rtl/audio_frame_scheduler.sv - stereo pair FIFO between SPI sample input and I2S frame requests
//
// Purpose:
//   Collects alternating left/right words from the SPI deserializer into
//   stereo pairs, buffers them in a small FIFO and serves one pair to the
//   I2S transmitter per frame request. Streaming starts or resumes only
//   after PREFILL pairs are buffered. Requests that find no data produce zeros.
//
// Parameters:
//   DEPTH    FIFO depth in stereo pairs (power of two, >= 2)
//   PREFILL  pairs held before streaming starts or resumes (1..DEPTH)
//
// Ports:
//   input_clk     sole clock, rising edge
//   reset         asynchronous active-low reset
//   spi_cs        active-low stream enable from the SPI host
//   rx_word       sample word from the SPI deserializer
//   rx_valid      one-cycle strobe qualifying rx_word
//   frame_req     one-cycle strobe at the start of each I2S stereo frame
//   left_sample   left-channel word for the I2S transmitter
//   right_sample  right-channel word for the I2S transmitter
//   sample_load   one-cycle strobe; samples updated this cycle
//   fifo_level    stereo pairs currently buffered
//   underrun      sticky; a frame was served with no data
//   overrun       sticky; a pair was dropped because the FIFO was full
//   RED_LED       underrun or overrun seen
//   GREEN_LED     streaming
//   BLUE_LED      prefilling or recovering from underrun

module audio_frame_scheduler #(
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2
) (
  input  logic                     input_clk,
  input  logic                     reset,
  input  logic                     spi_cs,
  input  logic [31:0]              rx_word,
  input  logic                     rx_valid,
  input  logic                     frame_req,
  output logic [31:0]              left_sample,
  output logic [31:0]              right_sample,
  output logic                     sample_load,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  output logic                     overrun,
  output logic                     RED_LED,
  output logic                     GREEN_LED,
  output logic                     BLUE_LED
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFILL  = 2'd1,
    S_STREAM   = 2'd2,
    S_UNDERRUN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LVL_W-1:0]   level;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               parity;    // 0: next word is left, 1: next word is right
  logic [31:0]        stage;
  logic [63:0]        mem [DEPTH];

  logic rx_take;
  logic push_req;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;
  logic starve;
  logic refilled;

  // Words are only taken while the stream is enabled and the FIFO is not
  // being flushed in IDLE.
  assign rx_take  = rx_valid && !spi_cs && (state != S_IDLE);
  assign push_req = rx_take && parity;
  assign full     = (level == LVL_W'(DEPTH));
  // Pop is gated on the registered level, so a same-cycle push into an
  // empty FIFO is never forwarded straight to the output.
  assign pop      = frame_req && (state == S_STREAM) && (level != '0);
  // A full FIFO still accepts a pair if a pop frees a slot the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign starve   = frame_req && (state == S_STREAM) && (level == '0);
  assign refilled = (level >= LVL_W'(PREFILL));

  // State register
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; deasserting spi_cs always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (!spi_cs) state_nxt = S_PREFILL;
      S_PREFILL:  if (spi_cs) state_nxt = S_IDLE;
                  else if (refilled) state_nxt = S_STREAM;
      S_STREAM:   if (spi_cs) state_nxt = S_IDLE;
                  else if (starve) state_nxt = S_UNDERRUN;
      S_UNDERRUN: if (spi_cs) state_nxt = S_IDLE;
                  else if (refilled) state_nxt = S_STREAM;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    GREEN_LED = (state == S_STREAM);
    BLUE_LED  = (state == S_PREFILL) || (state == S_UNDERRUN);
    RED_LED   = underrun || overrun;
  end

  assign fifo_level = level;

  // FIFO pointers, level, staging register and word parity
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      parity <= 1'b0;
      stage  <= '0;
    end else if (state == S_IDLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      parity <= 1'b0;
      stage  <= '0;
    end else begin
      if (rx_take) begin
        if (!parity) stage <= rx_word;
        // Parity toggles even when the pair is dropped, keeping L/R aligned.
        parity <= !parity;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push_ok) level <= level - LVL_W'(1);
    end
  end

  // Pair storage; contents are don't-care until written, so no reset.
  always_ff @(posedge input_clk) begin
    if (push_ok) mem[wr_ptr] <= {stage, rx_word};
  end

  // Sticky error flags, cleared when a new stream begins
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (!spi_cs) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end
    end else begin
      if (starve) underrun <= 1'b1;
      if (drop)   overrun  <= 1'b1;
    end
  end

  // Every request is answered exactly one cycle later, in any state.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      sample_load  <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
    end else begin
      sample_load <= frame_req;
      if (frame_req) begin
        if (pop) {left_sample, right_sample} <= mem[rd_ptr];
        else     {left_sample, right_sample} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb/tb_audio_frame_scheduler.sv - scoreboard bench for audio_frame_scheduler

module tb_audio_frame_scheduler;

  logic        serial_clk_tb = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs = 1'b1;
  logic [31:0] rx_word = '0;
  logic        rx_valid = 1'b0;
  logic        frame_req = 1'b0;
  logic [31:0] left_sample;
  logic [31:0] right_sample;
  logic        sample_load;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        overrun;
  logic        RED_LED;
  logic        GREEN_LED;
  logic        BLUE_LED;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic fr_d = 1'b0;

  always #5 serial_clk_tb = ~serial_clk_tb;

  audio_frame_scheduler #(.DEPTH(4), .PREFILL(2)) dut (
    .input_clk    (serial_clk_tb),
    .reset        (reset),
    .spi_cs       (spi_cs),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .frame_req    (frame_req),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_load  (sample_load),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .overrun      (overrun),
    .RED_LED      (RED_LED),
    .GREEN_LED    (GREEN_LED),
    .BLUE_LED     (BLUE_LED)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge serial_clk_tb);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    rx_word  = w;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    send_word(l);
    send_word(r);
  endtask

  task automatic frame(input logic [63:0] exp);
    exp_q.push_back(exp);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic leds(input string tag, input logic [2:0] rgb);
    chk(tag, {RED_LED, GREEN_LED, BLUE_LED}, rgb);
  endtask

  always @(posedge serial_clk_tb) fr_d <= frame_req;

  // Scoreboard: every request must load exactly one cycle later with the
  // pair the stimulus queued for it.
  always @(negedge serial_clk_tb) begin
    if (fr_d || sample_load) begin
      chk("load_latency", sample_load, fr_d);
      if (sample_load) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        else chk("sample_pair", {left_sample, right_sample}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset is asserted without a clock edge and must clear outputs at once.
    #1 reset = 1'b0;
    #1;
    chk("rst_samples", {left_sample, right_sample}, 64'd0);
    chk("rst_load_level", {sample_load, fifo_level}, 4'd0);
    chk("rst_flags", {underrun, overrun}, 2'd0);
    leds("rst_leds", 3'b000);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Stream disabled: requests still answered with zeros
    frame(64'd0);
    frame(64'd0);
    tick();
    leds("idle_leds", 3'b000);
    chk("idle_level", fifo_level, 3'd0);

    // Basic prefill and streaming
    spi_cs = 1'b0;
    tick(); tick();
    leds("prefill_leds", 3'b001);
    send_pair(32'hA0A0_0001, 32'hB0B0_0002);
    chk("one_pair_no_stream", GREEN_LED, 1'b0);
    chk("one_pair_level", fifo_level, 3'd1);
    send_pair(32'hC0C0_0003, 32'hD0D0_0004);
    tick();
    leds("stream_leds", 3'b010);
    chk("two_pair_level", fifo_level, 3'd2);
    frame({32'hA0A0_0001, 32'hB0B0_0002});
    frame({32'hC0C0_0003, 32'hD0D0_0004});
    tick(); tick(); tick();
    chk("hold_between_loads", {left_sample, right_sample}, {32'hC0C0_0003, 32'hD0D0_0004});
    chk("drained_level", fifo_level, 3'd0);

    // Underrun and recovery
    send_pair(32'hE0E0_0005, 32'hF0F0_0006);
    send_pair(32'h1111_0007, 32'h2222_0008);
    frame({32'hE0E0_0005, 32'hF0F0_0006});
    frame({32'h1111_0007, 32'h2222_0008});
    frame(64'd0);
    chk("underrun_set", underrun, 1'b1);
    leds("underrun_leds", 3'b101);
    send_pair(32'h3333_0009, 32'h4444_000A);
    send_pair(32'h5555_000B, 32'h6666_000C);
    tick();
    leds("recovered_leds", 3'b110);
    frame({32'h3333_0009, 32'h4444_000A});
    frame({32'h5555_000B, 32'h6666_000C});
    tick();

    // Overrun: fifth pair dropped, sixth pair accepted alongside a pop
    for (int i = 1; i <= 4; i++) send_pair(32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i));
    chk("full_level", fifo_level, 3'd4);
    chk("no_overrun_yet", overrun, 1'b0);
    send_pair(32'h7000_0005, 32'h8000_0005);
    chk("overrun_set", overrun, 1'b1);
    chk("overrun_level", fifo_level, 3'd4);
    send_word(32'h7000_0006);
    rx_word   = 32'h8000_0006;
    rx_valid  = 1'b1;
    frame_req = 1'b1;
    exp_q.push_back({32'h7000_0001, 32'h8000_0001});
    tick();
    rx_valid  = 1'b0;
    frame_req = 1'b0;
    chk("push_pop_full_level", fifo_level, 3'd4);
    for (int i = 2; i <= 4; i++) frame({32'h7000_0000 + 32'(i), 32'h8000_0000 + 32'(i)});
    frame({32'h7000_0006, 32'h8000_0006});
    tick();
    chk("overrun_drained", fifo_level, 3'd0);

    // Half pair discarded across an spi_cs toggle; flags cleared on restart
    send_pair(32'h9000_0001, 32'h9000_0002);
    send_word(32'h9000_0003);
    spi_cs = 1'b1;
    tick(); tick();
    chk("cs_high_flush", fifo_level, 3'd0);
    leds("cs_high_leds", 3'b100);
    spi_cs = 1'b0;
    tick();
    chk("flags_cleared", {underrun, overrun}, 2'd0);
    leds("restart_leds", 3'b001);
    send_pair(32'hABCD_0001, 32'hABCD_0002);
    send_pair(32'hABCD_0003, 32'hABCD_0004);
    tick();
    frame({32'hABCD_0001, 32'hABCD_0002});
    frame({32'hABCD_0003, 32'hABCD_0004});
    tick();

    // Reset in the middle of a stream with three pairs buffered
    for (int i = 1; i <= 3; i++) send_pair(32'hCC00_0000 + 32'(i), 32'hDD00_0000 + 32'(i));
    chk("pre_reset_level", fifo_level, 3'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_samples", {left_sample, right_sample}, 64'd0);
    chk("mid_rst_level", fifo_level, 3'd0);
    leds("mid_rst_leds", 3'b000);
    tick(); tick();
    reset = 1'b1;
    tick();
    frame(64'd0);
    frame(64'd0);
    chk("post_rst_level", fifo_level, 3'd0);
    send_pair(32'hEE00_0001, 32'hFF00_0001);
    send_pair(32'hEE00_0002, 32'hFF00_0002);
    tick();
    frame({32'hEE00_0001, 32'hFF00_0001});
    tick(); tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
